ea_reg_access_arbiter: RTL

//   Shares the single block_ea register bus between register-access requesters (src0 = UART

---
 rtl/ea_reg_access_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ea_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// ea_reg_access_arbiter
//   Shares the single block_ea register bus between register-access
//   requesters (src0 = UART command path, src1 = MAC command path).
//   Round-robin grant, one transaction in flight, read responses routed back
//   to the issuing source, read timeout, and per-source request/ack counters.
//
// Ports
//   clk, rst_n       single clock, synchronous active-low reset
//   cnt_clr          one-cycle pulse clearing every counter
//   req_valid/ready  per-source request handshake (ready only in IDLE)
//   req_write        per-source 1 = write, 0 = read
//   req_addr         per-source byte address, source i at [ADDR_W*i +: ADDR_W]
//   req_wdata        per-source write data, source i at [32*i +: 32]
//   rsp_valid        one-cycle read-response strobe to the issuing source
//   rsp_rdata        read data, valid with any rsp_valid bit
//   rsp_err          timeout or misaligned address, valid with rsp_valid
//   reg_valid/ready  register-bus command handshake
//   reg_write        register-bus write/read
//   reg_addr         register-bus address (always word aligned)
//   reg_wdata        register-bus write data
//   reg_rvalid/rdata register-bus read return
//   wr_req_cnt       accepted writes per source, 32 bits each
//   rd_req_cnt       accepted reads per source, 32 bits each
//   rd_ack_cnt       read responses delivered per source, 32 bits each
// ---------------------------------------------------------------------------
module ea_reg_access_arbiter #(
   parameter int          NUM_SRC        = 2,
   parameter int          ADDR_W         = 16,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cnt_clr,
   input  logic [NUM_SRC-1:0]        req_valid,
   output logic [NUM_SRC-1:0]        req_ready,
   input  logic [NUM_SRC-1:0]        req_write,
   input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
   input  logic [NUM_SRC*32-1:0]     req_wdata,
   output logic [NUM_SRC-1:0]        rsp_valid,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err,
   output logic                      reg_valid,
   input  logic                      reg_ready,
   output logic                      reg_write,
   output logic [ADDR_W-1:0]         reg_addr,
   output logic [31:0]               reg_wdata,
   input  logic                      reg_rvalid,
   input  logic [31:0]               reg_rdata,
   output logic [NUM_SRC*32-1:0]     wr_req_cnt,
   output logic [NUM_SRC*32-1:0]     rd_req_cnt,
   output logic [NUM_SRC*32-1:0]     rd_ack_cnt
);

   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT_RD = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   logic [1:0]        state;
   logic [SRC_W-1:0]  last_grant;
   logic [SRC_W-1:0]  src_q;
   logic [TMR_W-1:0]  timer;

   logic [SRC_W-1:0]  grant;
   logic [SRC_W-1:0]  cand;
   logic              grant_found;
   logic              grant_write;
   logic [ADDR_W-1:0] grant_addr;
   logic [31:0]       grant_wdata;
   logic              accept;
   logic              misaligned;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      grant_found = 1'b0;
      grant       = '0;
      cand        = '0;
      grant_addr  = '0;
      grant_wdata = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant       = cand;
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SRC_W'(i)) begin
            grant_addr  = req_addr[ADDR_W*i +: ADDR_W];
            grant_wdata = req_wdata[32*i +: 32];
         end
      end
   end

   assign grant_write = req_write[grant];
   assign misaligned  = (grant_addr[1:0] != 2'b00);
   // Gated by rst_n so no source sees an accept while reset is asserted.
   assign accept      = rst_n && (state == ST_IDLE) && grant_found;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   // Transaction FSM and bus/response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state      <= ST_IDLE;
         last_grant <= SRC_W'(NUM_SRC - 1);
         src_q      <= '0;
         timer      <= '0;
         reg_valid  <= 1'b0;
         reg_write  <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  last_grant <= grant;
                  src_q      <= grant;
                  if (!misaligned) begin
                     // Only aligned commands ever reach the bus registers.
                     reg_valid <= 1'b1;
                     reg_write <= grant_write;
                     reg_addr  <= grant_addr;
                     reg_wdata <= grant_wdata;
                     state     <= ST_ISSUE;
                  end else if (!grant_write) begin
                     rsp_valid[grant] <= 1'b1;
                     rsp_rdata        <= '0;
                     rsp_err          <= 1'b1;
                     state            <= ST_RESP;
                  end
                  // A misaligned write is silently dropped and stays in IDLE.
               end
            end
            ST_ISSUE: begin
               if (reg_ready) begin
                  reg_valid <= 1'b0;
                  timer     <= '0;
                  state     <= reg_write ? ST_IDLE : ST_WAIT_RD;
               end
            end
            ST_WAIT_RD: begin
               timer <= timer + 1'b1;
               // Read data arriving on the timeout cycle takes priority.
               if (reg_rvalid) begin
                  rsp_valid[src_q] <= 1'b1;
                  rsp_rdata        <= reg_rdata;
                  rsp_err          <= 1'b0;
                  state            <= ST_RESP;
               end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid[src_q] <= 1'b1;
                  rsp_rdata        <= TIMEOUT_DATA;
                  rsp_err          <= 1'b1;
                  state            <= ST_RESP;
               end
            end
            ST_RESP:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Per-source counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_req_cnt <= '0;
         rd_req_cnt <= '0;
         rd_ack_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (cnt_clr) begin
               wr_req_cnt[32*i +: 32] <= '0;
               rd_req_cnt[32*i +: 32] <= '0;
               rd_ack_cnt[32*i +: 32] <= '0;
            end else begin
               if (accept && (grant == SRC_W'(i))) begin
                  if (grant_write) wr_req_cnt[32*i +: 32] <= wr_req_cnt[32*i +: 32] + 32'd1;
                  else             rd_req_cnt[32*i +: 32] <= rd_req_cnt[32*i +: 32] + 32'd1;
               end
               if ((state == ST_RESP) && (src_q == SRC_W'(i)))
                  rd_ack_cnt[32*i +: 32] <= rd_ack_cnt[32*i +: 32] + 32'd1;
            end
         end
      end
   end

endmodule
